// File: rtl/micro_tile_mux_ctrl.sv
// Tile selector: holds the chosen tile out of reset, muxes its output into a
// register, and sequences a fixed-length reset window on every switch.
module micro_tile_mux_ctrl #(
  parameter int N_TILES           = 8,
  parameter int OUT_W             = 8,
  parameter int SEL_W             = $clog2(N_TILES),
  parameter int SWITCH_RST_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     sel_load,
  input  logic [N_TILES*OUT_W-1:0] tile_out,
  output logic [N_TILES-1:0]       tile_rst,
  output logic [N_TILES-1:0]       tile_ena,
  output logic [OUT_W-1:0]         uo_out,
  output logic [SEL_W-1:0]         sel_cur,
  output logic                     busy,
  output logic                     sel_err
);

  typedef enum logic {ST_SWITCH, ST_RUN} state_t;

  localparam logic [7:0]   CNT_INIT = 8'(SWITCH_RST_CYCLES - 1);
  localparam logic [SEL_W:0] NT     = (SEL_W + 1)'(N_TILES);

  state_t                          state_q, state_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic [SEL_W-1:0]                sel_q, sel_d;
  logic [OUT_W-1:0]                uo_q, uo_d;
  logic                            err_q, err_d;
  logic [N_TILES-1:0][OUT_W-1:0]   tiles;
  logic                            req_ok;

  assign tiles  = tile_out;
  assign req_ok = ({1'b0, sel_req} < NT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SWITCH;
      cnt_q   <= CNT_INIT;
      sel_q   <= '0;
      uo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      uo_q    <= uo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    uo_d    = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_SWITCH: begin
        if (cnt_q == 8'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        uo_d = tiles[sel_q];
        if (sel_load) begin
          if (req_ok) begin
            // accepted switch: blank the output from the first SWITCH cycle on
            sel_d   = sel_req;
            cnt_d   = CNT_INIT;
            state_d = ST_SWITCH;
            uo_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign busy    = (state_q == ST_SWITCH);
  assign sel_cur = sel_q;
  assign uo_out  = uo_q;
  assign sel_err = err_q;

  for (genvar i = 0; i < N_TILES; i++) begin : g_tile
    assign tile_ena[i] = (sel_q == SEL_W'(i));
    assign tile_rst[i] = busy | ~tile_ena[i];
  end

endmodule

// File: tb/tb_micro_tile_mux_ctrl.sv
// Directed vector bench: a 4-tile instance driven from a table, and a 3-tile
// instance for out-of-range request handling.
module tb_micro_tile_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_req;
  logic        sel_load;
  logic [31:0] tile_out;
  logic [3:0]  tile_rst, tile_ena;
  logic [7:0]  uo_out;
  logic [1:0]  sel_cur;
  logic        busy, sel_err;

  logic        rst3;
  logic [1:0]  sel_req3;
  logic        sel_load3;
  logic [23:0] tile_out3;
  logic [2:0]  tile_rst3, tile_ena3;
  logic [7:0]  uo_out3;
  logic [1:0]  sel_cur3;
  logic        busy3, sel_err3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  micro_tile_mux_ctrl #(.N_TILES(4), .OUT_W(8), .SWITCH_RST_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .sel_load(sel_load),
    .tile_out(tile_out), .tile_rst(tile_rst), .tile_ena(tile_ena),
    .uo_out(uo_out), .sel_cur(sel_cur), .busy(busy), .sel_err(sel_err));

  micro_tile_mux_ctrl #(.N_TILES(3), .OUT_W(8), .SEL_W(2), .SWITCH_RST_CYCLES(4)) u_dut3 (
    .clk(clk), .rst(rst3), .sel_req(sel_req3), .sel_load(sel_load3),
    .tile_out(tile_out3), .tile_rst(tile_rst3), .tile_ena(tile_ena3),
    .uo_out(uo_out3), .sel_cur(sel_cur3), .busy(busy3), .sel_err(sel_err3));

  typedef struct {
    logic        rst;
    logic        ld;
    logic [1:0]  req;
    logic [31:0] tiles;
    logic        busy;
    logic [3:0]  trst;
    logic [1:0]  sel;
    logic [7:0]  uo;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] T0 = 32'h3CA5_2110;
  localparam logic [31:0] T1 = 32'h3CA5_2155;

  function automatic vec_t mk(logic r, logic l, logic [1:0] q, logic [31:0] t,
                              logic b, logic [3:0] tr, logic [1:0] s,
                              logic [7:0] u, logic e);
    vec_t v;
    v.rst = r; v.ld = l; v.req = q; v.tiles = t;
    v.busy = b; v.trst = tr; v.sel = s; v.uo = u; v.err = e;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step3(logic r, logic l, logic [1:0] q);
    @(negedge clk);
    rst3 = r; sel_load3 = l; sel_req3 = q;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; sel_load = 1'b0; sel_req = '0; tile_out = T0;
    rst3 = 1'b1; sel_load3 = 1'b0; sel_req3 = '0; tile_out3 = 24'h33_2211;

    // power-on: two reset edges, four busy cycles, then RUN on tile 0
    vecs.push_back(mk(1,0,0,T0, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(1,0,0,T0, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T0, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T0, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T0, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T0, 0,4'hE,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T0, 0,4'hE,0,8'h10,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hE,0,8'h55,0));
    // switch to tile 2
    vecs.push_back(mk(0,1,2,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hB,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hB,2,8'hA5,0));
    // same-tile restart
    vecs.push_back(mk(0,1,2,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hB,2,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hB,2,8'hA5,0));
    // load while busy is ignored
    vecs.push_back(mk(0,1,3,T1, 1,4'hF,3,8'h00,0));
    vecs.push_back(mk(0,1,1,T1, 1,4'hF,3,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,3,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,3,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'h7,3,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'h7,3,8'h3C,0));
    // reset on the second SWITCH cycle toward tile 3
    vecs.push_back(mk(0,1,3,T1, 1,4'hF,3,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,3,8'h00,0));
    vecs.push_back(mk(1,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hE,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hE,0,8'h55,0));
    // reset wins over a simultaneous load
    vecs.push_back(mk(1,1,2,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 1,4'hF,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hE,0,8'h00,0));
    vecs.push_back(mk(0,0,0,T1, 0,4'hE,0,8'h55,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; sel_load = vecs[i].ld; sel_req = vecs[i].req;
      tile_out = vecs[i].tiles;
      @(posedge clk); #1;
      chk("busy",     i, 32'(busy),     32'(vecs[i].busy));
      chk("tile_rst", i, 32'(tile_rst), 32'(vecs[i].trst));
      chk("tile_ena", i, 32'(tile_ena), 32'(4'b0001 << vecs[i].sel));
      chk("sel_cur",  i, 32'(sel_cur),  32'(vecs[i].sel));
      chk("uo_out",   i, 32'(uo_out),   32'(vecs[i].uo));
      chk("sel_err",  i, 32'(sel_err),  32'(vecs[i].err));
    end

    // three-tile instance: bring up, then an out-of-range request
    step3(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step3(0, 0, 0);
      chk("n3_busy_pwr", k, 32'(busy3), 32'(k < 3));
    end
    chk("n3_trst_run", 0, 32'(tile_rst3), 32'(3'b110));
    step3(0, 0, 0);
    chk("n3_uo", 0, 32'(uo_out3), 32'h11);
    step3(0, 1, 3);
    chk("n3_err_pulse", 0, 32'(sel_err3),  32'd1);
    chk("n3_err_sel",   0, 32'(sel_cur3),  32'd0);
    chk("n3_err_busy",  0, 32'(busy3),     32'd0);
    chk("n3_err_trst",  0, 32'(tile_rst3), 32'(3'b110));
    step3(0, 0, 0);
    chk("n3_err_clear", 0, 32'(sel_err3),  32'd0);
    chk("n3_err_sel2",  0, 32'(sel_cur3),  32'd0);
    step3(0, 1, 2);
    chk("n3_ok_busy",   0, 32'(busy3),     32'd1);
    chk("n3_ok_sel",    0, 32'(sel_cur3),  32'd2);
    chk("n3_ok_err",    0, 32'(sel_err3),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/micro_tile_mux_ctrl.md
MICRO_TILE_MUX_CTRL -- requirements
Module: micro_tile_mux_ctrl

Interface
REQ-001 SHALL have parameter N_TILES, default 8: number of tile slots, legal range 2..16.
REQ-002 SHALL have parameter OUT_W, default 8: output width of each tile.
REQ-003 SHALL have parameter SEL_W, default clog2(N_TILES): selector width.
REQ-004 SHALL have parameter SWITCH_RST_CYCLES, default 4: reset hold length on a tile switch, legal range 1..255.
REQ-005 SHALL have port clk, input, 1: single clock; every register in the block is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port sel_req, input, SEL_W: requested tile index.
REQ-008 SHALL have port sel_load, input, 1: single-cycle strobe that requests a switch to sel_req.
REQ-009 SHALL have port tile_out, input, N_TILES*OUT_W: flattened tile outputs; tile i occupies bits [i*OUT_W +: OUT_W].
REQ-010 SHALL have port tile_rst, output, N_TILES: per-tile reset, active-high.
REQ-011 SHALL have port tile_ena, output, N_TILES: one-hot enable for the active tile.
REQ-012 SHALL have port uo_out, output, OUT_W: registered output of the selected tile.
REQ-013 SHALL have port sel_cur, output, SEL_W: index of the currently selected tile.
REQ-014 SHALL have port busy, output, 1: high while a switch is in progress.
REQ-015 SHALL have port sel_err, output, 1: one-cycle pulse flagging a rejected request.

Function
REQ-016 SHALL implement a two-state FSM, SWITCH and RUN, plus a down-counter cnt of 8 bits.
REQ-017 SHALL, in SWITCH: decrement cnt each cycle; when cnt==0, move to RUN on the next edge; SWITCH therefore lasts exactly SWITCH_RST_CYCLES cycles.
REQ-018 SHALL, in RUN, accept sel_load with sel_req<N_TILES: sel_cur<=sel_req, cnt<=SWITCH_RST_CYCLES-1, state<=SWITCH.
REQ-019 SHALL treat sel_load in RUN with sel_req==sel_cur as a valid request that re-resets the same tile (soft restart).
REQ-020 SHALL, on sel_load in RUN with sel_req>=N_TILES: ignore the request, pulse sel_err for one cycle, and leave state and sel_cur unchanged.
REQ-021 SHALL ignore sel_load in SWITCH, without asserting sel_err.
REQ-022 SHALL drive busy=1 iff state==SWITCH, combinationally from state.
REQ-023 SHALL drive tile_ena = one-hot(sel_cur) in both states.
REQ-024 SHALL, in RUN, drive tile_rst=1 for every tile except sel_cur and tile_rst[sel_cur]=0.
REQ-025 SHALL, in SWITCH, drive tile_rst to all ones.
REQ-026 SHALL register uo_out: in RUN, uo_out<=tile_out slice of sel_cur (1-cycle latency); in SWITCH, uo_out<=0.
REQ-027 SHALL make the first non-zero-forced uo_out visible one cycle after the first RUN cycle.
REQ-028 SHALL, when sel_load and rst are asserted together, let rst take priority and ignore the request.

Reset
REQ-029 SHALL, while rst=1 at an edge, set state=SWITCH, sel_cur=0, cnt=SWITCH_RST_CYCLES-1, uo_out=0, sel_err=0.
REQ-030 SHALL, as a consequence, hold tile_rst all ones and set tile_ena=1, busy=1 during and after reset until the power-on switch completes.
REQ-031 SHALL, on reset asserted mid-switch or mid-run, abandon the current target and restart the power-on sequence to tile 0.

Verification (N_TILES=4, OUT_W=8, SWITCH_RST_CYCLES=4)
REQ-032 SHALL cover power-on: rst for 2 cycles, then release -> busy=1 for 4 cycles; tile_rst=4'b1110 from the 5th cycle; uo_out follows tile 0 one cycle later.
REQ-033 SHALL cover a valid switch: in RUN, sel_load with sel_req=2 and tile_out[23:16]=8'hA5 -> sel_cur=2; tile_rst=4'b1111 for 4 cycles, then 4'b1011; uo_out=8'h00 throughout SWITCH, then 8'hA5.
REQ-034 SHALL cover a same-tile restart: in RUN on tile 2, sel_load with sel_req=2 -> busy=1 for 4 cycles, tile_rst[2]=1 for 4 cycles, sel_cur stays 2.
REQ-035 SHALL cover an out-of-range request (N_TILES=3, SEL_W=2): sel_load with sel_req=3 -> sel_err=1 for exactly one cycle; sel_cur, busy and tile_rst unchanged.
REQ-036 SHALL cover a load while busy: second sel_load with sel_req=1 during SWITCH to tile 3 -> ignored; RUN ends with sel_cur=3 and sel_err stays 0.
REQ-037 SHALL cover reset mid-switch: rst pulse on the 2nd SWITCH cycle toward tile 3 -> sel_cur=0, a full 4-cycle SWITCH, then RUN on tile 0.
